// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch-side, mem-stage and memory-side signals around mem_arbiter.
// slave  : the arbiter's view (requests and memory responses come in).
// master : the surrounding pipeline/memory view that drives the requests.
interface mem_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_stall;

  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_stall;

  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        bus_err;

  modport slave (
    input  inst_req, inst_addr, data_req, data_wr, data_addr, data_wdata,
           mem_rdata, mem_ack,
    output inst_rdata, inst_stall, data_rdata, data_stall,
           mem_req, mem_wr, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output inst_req, inst_addr, data_req, data_wr, data_addr, data_wdata,
           mem_rdata, mem_ack,
    input  inst_rdata, inst_stall, data_rdata, data_stall,
           mem_req, mem_wr, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and the
// mem stage. Data wins in IDLE; a finished data access hands straight over to a
// waiting fetch so the fetch side always makes progress. Accesses that see no
// mem_ack within WAIT_MAX cycles are terminated and flag a sticky bus_err.
module mem_arbiter #(
  parameter int unsigned WAIT_MAX = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DACC  = 3'd1;
  localparam logic [2:0] DRESP = 3'd2;
  localparam logic [2:0] IACC  = 3'd3;
  localparam logic [2:0] IRESP = 3'd4;

  localparam int unsigned CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_MAX - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] waitCnt;
  logic             startData;
  logic             startInst;
  logic             inAcc;
  logic             memDone;
  logic             timeOut;

  // Decode the next action from the registered state and the live requests.
  always_comb begin
    startData = (state == IDLE) && bus.data_req;
    startInst = ((state == IDLE) && !bus.data_req && bus.inst_req) ||
                ((state == DRESP) && bus.inst_req);
    inAcc     = (state == DACC) || (state == IACC);
    memDone   = inAcc && bus.mem_ack;
    timeOut   = inAcc && !bus.mem_ack && (waitCnt == LAST_WAIT);
  end

  // Stalls release for exactly the one response cycle of each requester.
  always_comb begin
    bus.data_stall = bus.data_req && (state != DRESP);
    bus.inst_stall = bus.inst_req && (state != IRESP);
  end

  // Arbitration FSM, registered memory request and response capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      waitCnt        <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_wr     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.inst_rdata <= '0;
      bus.data_rdata <= '0;
      bus.bus_err    <= 1'b0;
    end else if (startData) begin
      state         <= DACC;
      waitCnt       <= '0;
      bus.mem_req   <= 1'b1;
      bus.mem_wr    <= bus.data_wr;
      bus.mem_addr  <= bus.data_addr;
      bus.mem_wdata <= bus.data_wdata;
    end else if (startInst) begin
      state         <= IACC;
      waitCnt       <= '0;
      bus.mem_req   <= 1'b1;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= bus.inst_addr;
      bus.mem_wdata <= '0;
    end else if (memDone || timeOut) begin
      // The ack has priority over a timeout landing on the same cycle.
      state       <= (state == DACC) ? DRESP : IRESP;
      bus.mem_req <= 1'b0;
      bus.mem_wr  <= 1'b0;
      if (timeOut) begin
        bus.bus_err <= 1'b1;
        waitCnt     <= waitCnt + 1'b1;
      end
      if (state == IACC) begin
        bus.inst_rdata <= timeOut ? '0 : bus.mem_rdata;
      end else if (!bus.mem_wr) begin
        bus.data_rdata <= timeOut ? '0 : bus.mem_rdata;
      end
    end else if (inAcc) begin
      waitCnt <= waitCnt + 1'b1;
    end else if ((state == DRESP) || (state == IRESP)) begin
      state <= IDLE;
    end
  end

endmodule
